serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial, LSB-first adder built around the team's half-adder cell. Each bit slice is two half-adder instances plus an OR gate, forming a full adder.
- Accepts two WIDTH-bit operands and a carry-in on a start pulse.
- Adds one bit per clock.
- Presents the full sum and carry-out with a one-cycle done pulse.
- Sits downstream of the half-adder cell, as the first sequential arithmetic stage in the lab datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while an addition is in progress (state RUN)
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  result; held stable until the next accepted start
- cout  output  1  final carry-out; held with sum

Behaviour:
- Reset (rst_n=0, asynchronous; internally deasserted synchronously is not required):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter are all cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> latch a, b, cin into opA, opB, carry; counter=0; state=RUN; busy=1 from edge k.
- RUN, once per edge:
  - bit = opA[0]^opB[0]^carry.
  - carry <= (opA[0]&opB[0]) | (carry&(opA[0]^opB[0])).
  - opA/opB shift right by 1.
  - sum shift register shifts right with bit inserted at MSB.
  - counter += 1.
  - When counter reaches WIDTH-1 on this edge, next state=DONE.
- Latency: RUN occupies exactly WIDTH edges (k+1..k+WIDTH). At edge k+WIDTH:
  - state=DONE, busy=0, done=1.
  - sum holds the full result; cout = final carry.
- DONE: done=1 for exactly one cycle.
  - start=1 -> accepted immediately, same as in IDLE (back-to-back operation; done drops, busy rises).
  - Otherwise -> IDLE.
- start while in RUN: ignored. Operands are not re-latched and the counter is not disturbed.
- sum/cout:
  - Not updated externally during RUN. An internal shadow register accumulates the result; the outputs load on the DONE transition.
  - Sum is therefore never observed partially shifted.
  - Outputs hold until the next DONE or reset.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No truncation errors.
- Reset mid-RUN: immediate abort. All outputs return to reset values; no done pulse is produced.
- a/b/cin changing during RUN: no effect on the result.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit).
  - Signed two's-complement overflow: carry into MSB XOR carry out of MSB.
  - Captured on the final RUN edge and updated with sum/cout.
  - Reset value 0; held with sum.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, reset released, a=8'h3C, b=8'h5A, cin=0, start 1 cycle -> busy for 8 cycles; done at edge k+8; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
- Start asserted again at cycles k+3 and k+5 during RUN with a=8'h11 -> ignored; the original result is produced, then IDLE.
- start held high across DONE (second operands a=8'h01, b=8'h02):
  - done pulses once for the first result;
  - RUN restarts with no IDLE gap;
  - second done gives sum=8'h03, cout=0.
- rst_n pulled low at cycle k+4 mid-RUN -> busy=0, done=0, sum=0, cout=0 asynchronously; no done afterwards until a new start.
- With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder built from two half-adder cells per slice.
// Optional signed overflow output enabled by SERIAL_ADDER_OVF_EN.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic p, g, sbit, pc, carry_nx;

    half_adder u_ha0 (.a(op_a[0]), .b(op_b[0]), .s(p), .c(g));
    half_adder u_ha1 (.a(p), .b(carry), .s(sbit), .c(pc));

    assign carry_nx = g | pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            shadow <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry  <= carry_nx;
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    shadow <= {sbit, shadow[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    // Outputs load only on the last slice so sum never shows partial data.
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= {sbit, shadow[WIDTH-1:1]};
                        cout  <= carry_nx;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ carry_nx;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against a cycle-level
// arithmetic model; define SERIAL_ADDER_OVF_EN to cover the ovf port.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    // Model: remaining-cycle count plus plain integer addition.
    bit       m_busy = 0, m_done = 0, m_cout = 0, m_ovf = 0;
    bit [7:0] m_sum = 0;
    int       m_left = 0;
    bit [7:0] p_sum;
    bit       p_cout, p_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_sum = 0;
            m_cout = 0; m_ovf = 0; m_left = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1;
                m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_busy = 1;
                m_left = 8;
                {p_cout, p_sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                p_ovf = (a[7] == b[7]) && (p_sum[7] != a[7]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_sum", 32'(sum), 32'(m_sum));
            chk("cyc_cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Count cycles until done; poke re-asserts start mid-RUN with other operands.
    task automatic wait_done(input bit poke, output int cyc);
        cyc = 0;
        while (cyc < 20) begin
            step();
            cyc++;
            if (poke && (cyc == 3 || cyc == 5)) begin
                start = 1; a = 8'h11; b = 8'h11;
            end else begin
                start = 0;
            end
            if (done) break;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic op(input logic [7:0] ia, input logic [7:0] ib,
                      input logic ic, input bit poke,
                      input logic [7:0] es, input logic ec,
                      input string name);
        int cyc;
        a = ia; b = ib; cin = ic; start = 1;
        step();
        start = 0;
        wait_done(poke, cyc);
        chk({name, "_lat"}, 32'(cyc), 32'd8);
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 0; start = 0; a = 0; b = 0; cin = 0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1;
        chk_en = 1;
        step();

        op(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, "t1");
`ifdef SERIAL_ADDER_OVF_EN
        chk("t1_ovf", 32'(ovf), 32'd0);
`endif
        step();
        op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "t2a");
        op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "t2b");
        step();

        op(8'h25, 8'h4A, 1'b1, 1'b1, 8'h70, 1'b0, "ign");
        step();
        chk("ign_idle_busy", 32'(busy), 32'd0);
        chk("ign_idle_done", 32'(done), 32'd0);
        chk("ign_hold_sum", 32'(sum), 32'h70);
        step();

        // Back-to-back: start held through DONE.
        a = 8'hC8; b = 8'h64; cin = 0; start = 1;
        step();
        a = 8'h01; b = 8'h02;
        cyc = 0;
        while (cyc < 20 && !done) begin
            step();
            cyc++;
        end
        chk("b2b1_lat", 32'(cyc), 32'd8);
        chk("b2b1_sum", 32'(sum), 32'h2C);
        chk("b2b1_cout", 32'(cout), 32'd1);
        step();
        start = 0;
        chk("b2b_nogap_busy", 32'(busy), 32'd1);
        chk("b2b_nogap_done", 32'(done), 32'd0);
        wait_done(1'b0, cyc);
        chk("b2b2_lat", 32'(cyc), 32'd8);
        chk("b2b2_sum", 32'(sum), 32'h03);
        chk("b2b2_cout", 32'(cout), 32'd0);
        step();

        // Asynchronous reset mid-RUN.
        a = 8'h3C; b = 8'h5A; cin = 0; start = 1;
        step();
        start = 0;
        repeat (3) step();
        rst_n = 0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        step();
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("arst_nodone", 32'(done), 32'd0);
        end
        op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, "recover");
        step();

`ifdef SERIAL_ADDER_OVF_EN
        op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, "ovf1");
        chk("ovf1_ovf", 32'(ovf), 32'd1);
        step();
        op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, "ovf2");
        chk("ovf2_ovf", 32'(ovf), 32'd1);
        step();
`endif

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
